// File: rtl/cv32e40p_pkg.sv
// cv32e40p_pkg: shared types for the triple-replica scrub controller.
//   scrub_state_e - scrub FSM states (IDLE, READ, CHECK, REPAIR)
//   FAULT_*       - fault_id_o encodings (replica 3 and fatal share code 3)
//   ERRCNT_W      - width of the repaired-word counter
//   fault_id_of() - maps a one-hot mismatch mask to its fault id
package cv32e40p_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    CHECK  = 2'd2,
    REPAIR = 2'd3
  } scrub_state_e;

  localparam logic [1:0] FAULT_NONE  = 2'd0;
  localparam logic [1:0] FAULT_R1    = 2'd1;
  localparam logic [1:0] FAULT_R2    = 2'd2;
  localparam logic [1:0] FAULT_R3    = 2'd3;
  localparam logic [1:0] FAULT_FATAL = 2'd3;

  localparam int unsigned ERRCNT_W = 16;

  // Fault id of the single replica flagged in a one-hot mismatch mask.
  function automatic logic [1:0] fault_id_of(input logic [2:0] mask);
    logic [1:0] id;
    case (mask)
      3'b001:  id = FAULT_R1;
      3'b010:  id = FAULT_R2;
      3'b100:  id = FAULT_R3;
      default: id = FAULT_NONE;
    endcase
    return id;
  endfunction

endpackage

// File: rtl/cv32e40p_vote_classify.sv
// cv32e40p_vote_classify: combinational 2-of-3 voter.
//   i_d1..i_d3  - replica words
//   o_maj       - majority word (meaningless when o_all_diff is set)
//   o_mismatch  - bit k set when replica k+1 disagrees with both others
//   o_all_diff  - all three replicas differ pairwise
module cv32e40p_vote_classify #(
  parameter int unsigned NBIT = 32
) (
  input  logic [NBIT-1:0] i_d1,
  input  logic [NBIT-1:0] i_d2,
  input  logic [NBIT-1:0] i_d3,
  output logic [NBIT-1:0] o_maj,
  output logic [2:0]      o_mismatch,
  output logic            o_all_diff
);

  logic w_eq12;
  logic w_eq13;
  logic w_eq23;

  assign w_eq12 = (i_d1 == i_d2);
  assign w_eq13 = (i_d1 == i_d3);
  assign w_eq23 = (i_d2 == i_d3);

  // A replica is the odd one out when it matches neither of the others.
  assign o_mismatch[0] = ~w_eq12 & ~w_eq13;
  assign o_mismatch[1] = ~w_eq12 & ~w_eq23;
  assign o_mismatch[2] = ~w_eq13 & ~w_eq23;
  assign o_all_diff    = ~w_eq12 & ~w_eq13 & ~w_eq23;

  // Replica 1 is in the majority unless it is the odd one; then 2 and 3 agree.
  assign o_maj = (w_eq12 | w_eq13) ? i_d1 : i_d2;

endmodule

// File: rtl/cv32e40p_scrub_ctrl.sv
// cv32e40p_scrub_ctrl: background scrubber for a triple-replicated word store.
// Walks the address space, votes the three replicas, and rewrites a single
// disagreeing replica with the majority word. All three differing is fatal.
//
// Ports:
//   clk, rst_n        - clock, async active-low reset
//   scrub_en_i        - enable background scrubbing
//   core_busy_i       - core owns the replica port; no scrub read/write
//   core_wr_i         - core writes all replicas at core_waddr_i this cycle
//   addr_o, rd_en_o   - scrub address and read strobe (data returns next cycle)
//   rdata1..3_i       - replica read data
//   wr_en_o, wdata_o  - one-hot repair write enable and voted repair word
//   fault_id_o        - last fault class (0 none, 1-3 replica, 3 also fatal)
//   fatal_o           - sticky all-differ flag
//   err_cnt_o         - saturating repaired-word count
//   pass_done_o       - one-cycle pulse after the address wraps
//
// Configuration macro: CV32E40P_SCRUB_ERRCNT_EN enables the error counter;
// without it err_cnt_o is tied to zero.
module cv32e40p_scrub_ctrl
  import cv32e40p_pkg::*;
#(
  parameter  int unsigned NBIT   = 32,
  parameter  int unsigned DEPTH  = 32,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                scrub_en_i,
  input  logic                core_busy_i,
  input  logic                core_wr_i,
  input  logic [ADDR_W-1:0]   core_waddr_i,
  output logic [ADDR_W-1:0]   addr_o,
  output logic                rd_en_o,
  input  logic [NBIT-1:0]     rdata1_i,
  input  logic [NBIT-1:0]     rdata2_i,
  input  logic [NBIT-1:0]     rdata3_i,
  output logic [2:0]          wr_en_o,
  output logic [NBIT-1:0]     wdata_o,
  output logic [1:0]          fault_id_o,
  output logic                fatal_o,
  output logic [ERRCNT_W-1:0] err_cnt_o,
  output logic                pass_done_o
);

  scrub_state_e      r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [NBIT-1:0]   r_wdata;
  logic [2:0]        r_rep_mask;
  logic [1:0]        r_fault_id;
  logic              r_fatal;
  logic              r_pass_done;

  logic [NBIT-1:0]   w_maj;
  logic [2:0]        w_mismatch;
  logic              w_all_diff;
  logic              w_collide;
  logic              w_wr_go;
  logic              w_advance;
  logic              w_last;
  logic [ADDR_W-1:0] w_addr_nxt;

  cv32e40p_vote_classify #(
    .NBIT (NBIT)
  ) u_vote (
    .i_d1       (rdata1_i),
    .i_d2       (rdata2_i),
    .i_d3       (rdata3_i),
    .o_maj      (w_maj),
    .o_mismatch (w_mismatch),
    .o_all_diff (w_all_diff)
  );

  // A core write to the word under check makes the read data stale.
  assign w_collide = core_wr_i && (core_waddr_i == r_addr) &&
                     ((r_state == CHECK) || (r_state == REPAIR));

  // Repair write fires this cycle; a collision takes priority over it.
  assign w_wr_go = (r_state == REPAIR) && !core_busy_i && !w_collide;

  // Word finished: clean or fatal classification, or a completed repair.
  assign w_advance = w_wr_go ||
                     ((r_state == CHECK) && !w_collide && (w_all_diff || (w_mismatch == 3'b000)));

  assign w_last     = (r_addr == ADDR_W'(DEPTH - 1));
  assign w_addr_nxt = w_last ? '0 : r_addr + ADDR_W'(1);

  // Scrub FSM, address walker and fault status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rep_mask  <= '0;
      r_fault_id  <= FAULT_NONE;
      r_fatal     <= 1'b0;
      r_pass_done <= 1'b0;
    end else begin
      r_pass_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (scrub_en_i) r_state <= READ;
        end
        READ: begin
          if (!core_busy_i) r_state <= CHECK;
        end
        CHECK: begin
          if (w_collide) begin
            r_state <= READ;
          end else if (w_all_diff) begin
            r_fatal    <= 1'b1;
            r_fault_id <= FAULT_FATAL;
          end else if (w_mismatch != 3'b000) begin
            r_wdata    <= w_maj;
            r_rep_mask <= w_mismatch;
            r_fault_id <= fault_id_of(w_mismatch);
            r_state    <= REPAIR;
          end
        end
        REPAIR: begin
          if (w_collide) r_state <= READ;
        end
        default: r_state <= IDLE;
      endcase
      // Word complete: step the address; a dropped enable parks in IDLE here.
      if (w_advance) begin
        r_addr      <= w_addr_nxt;
        r_pass_done <= w_last;
        r_state     <= scrub_en_i ? READ : IDLE;
      end
    end
  end

`ifdef CV32E40P_SCRUB_ERRCNT_EN
  logic [ERRCNT_W-1:0] r_err_cnt;

  // Saturating count of completed repair writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
    end else if (w_wr_go && (r_err_cnt != {ERRCNT_W{1'b1}})) begin
      r_err_cnt <= r_err_cnt + ERRCNT_W'(1);
    end
  end

  assign err_cnt_o = r_err_cnt;
`else
  assign err_cnt_o = '0;
`endif

  // Strobes are qualified by this cycle's port ownership and collision, so
  // they decode the registered state rather than lag it by a cycle.
  assign rd_en_o     = (r_state == READ) && !core_busy_i;
  assign wr_en_o     = w_wr_go ? r_rep_mask : 3'b000;
  assign addr_o      = r_addr;
  assign wdata_o     = r_wdata;
  assign fault_id_o  = r_fault_id;
  assign fatal_o     = r_fatal;
  assign pass_done_o = r_pass_done;

endmodule

// File: tb/tb_cv32e40p_scrub_ctrl.sv
// tb_cv32e40p_scrub_ctrl: directed and randomized checks of the scrubber
// against a word-level replica memory and expected results derived per word.
module tb_cv32e40p_scrub_ctrl;

  localparam int unsigned NBIT   = 32;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ADDR_W = 2;

`ifdef CV32E40P_SCRUB_ERRCNT_EN
  localparam bit ERRCNT = 1'b1;
`else
  localparam bit ERRCNT = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              scrub_en_i = 1'b0;
  logic              core_busy_i = 1'b0;
  logic              core_wr_i = 1'b0;
  logic [ADDR_W-1:0] core_waddr_i = '0;
  logic [ADDR_W-1:0] addr_o;
  logic              rd_en_o;
  logic [NBIT-1:0]   rdata1_i = '0;
  logic [NBIT-1:0]   rdata2_i = '0;
  logic [NBIT-1:0]   rdata3_i = '0;
  logic [2:0]        wr_en_o;
  logic [NBIT-1:0]   wdata_o;
  logic [1:0]        fault_id_o;
  logic              fatal_o;
  logic [15:0]       err_cnt_o;
  logic              pass_done_o;

  cv32e40p_scrub_ctrl #(
    .NBIT  (NBIT),
    .DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .scrub_en_i   (scrub_en_i),
    .core_busy_i  (core_busy_i),
    .core_wr_i    (core_wr_i),
    .core_waddr_i (core_waddr_i),
    .addr_o       (addr_o),
    .rd_en_o      (rd_en_o),
    .rdata1_i     (rdata1_i),
    .rdata2_i     (rdata2_i),
    .rdata3_i     (rdata3_i),
    .wr_en_o      (wr_en_o),
    .wdata_o      (wdata_o),
    .fault_id_o   (fault_id_o),
    .fatal_o      (fatal_o),
    .err_cnt_o    (err_cnt_o),
    .pass_done_o  (pass_done_o)
  );

  always #5 clk = ~clk;

  // Replica store: mem[k] is replica k+1.
  logic [NBIT-1:0]   mem [3][DEPTH];
  logic [NBIT-1:0]   core_wdata = '0;

  logic              s_rd;
  logic [2:0]        s_wr;
  logic [ADDR_W-1:0] s_addr;
  logic [NBIT-1:0]   s_wdata;
  logic              s_pd;

  int n_checks = 0;
  int n_fail   = 0;
  int n_rd     = 0;
  int n_wr     = 0;
  int n_pd     = 0;
  int n_bad    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample strobes mid-cycle, then apply memory effects after the edge.
  task automatic step();
    @(negedge clk);
    s_rd    = rd_en_o;
    s_wr    = wr_en_o;
    s_addr  = addr_o;
    s_wdata = wdata_o;
    s_pd    = pass_done_o;
    if (s_rd) n_rd++;
    if (s_wr != 3'b000) n_wr++;
    if (s_pd) n_pd++;
    if (($countones(s_wr) > 1) || ((s_rd || (s_wr != 3'b000)) && core_busy_i)) n_bad++;
    @(posedge clk);
    #1;
    if (s_rd) begin
      rdata1_i = mem[0][s_addr];
      rdata2_i = mem[1][s_addr];
      rdata3_i = mem[2][s_addr];
    end
    for (int k = 0; k < 3; k++) if (s_wr[k]) mem[k][s_addr] = s_wdata;
    if (core_wr_i) for (int k = 0; k < 3; k++) mem[k][core_waddr_i] = core_wdata;
  endtask

  task automatic do_reset();
    scrub_en_i   = 1'b0;
    core_busy_i  = 1'b0;
    core_wr_i    = 1'b0;
    core_waddr_i = '0;
    rdata1_i     = '0;
    rdata2_i     = '0;
    rdata3_i     = '0;
    rst_n        = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    n_rd = 0;
    n_wr = 0;
    n_pd = 0;
  endtask

  task automatic fill(input logic [NBIT-1:0] v);
    for (int k = 0; k < 3; k++) for (int a = 0; a < int'(DEPTH); a++) mem[k][a] = v;
  endtask

  task automatic wait_rd(input logic [ADDR_W-1:0] a, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      step();
      if (s_rd && (s_addr == a)) ok = 1'b1;
    end
  endtask

  bit              ok;
  logic [7:0]      rd_seq;
  int              cls  [DEPTH];
  logic [NBIT-1:0] base [DEPTH];
  int              exp_nwr;
  int              exp_fid;
  bit              exp_fatal;
  int              bad_words;

  initial begin
    // Reset values while reset is held
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_addr",  32'(addr_o), 32'd0);
    chk("rst_rd",    32'(rd_en_o), 32'd0);
    chk("rst_wr",    32'(wr_en_o), 32'd0);
    chk("rst_wdata", 32'(wdata_o), 32'd0);
    chk("rst_fid",   32'(fault_id_o), 32'd0);
    chk("rst_fatal", 32'(fatal_o), 32'd0);
    chk("rst_err",   32'(err_cnt_o), 32'd0);
    chk("rst_pd",    32'(pass_done_o), 32'd0);

    // Clean pass: 2 cycles per word, 8 per pass, no writes
    fill(32'hA5A5_0F0F);
    do_reset();
    scrub_en_i = 1'b1;
    wait_rd(2'd0, ok);
    chk("clean_start", 32'(ok), 32'd1);
    n_rd = 1; n_wr = 0; n_pd = 0; rd_seq = 8'h00;
    for (int i = 0; i < 7; i++) begin
      step();
      if (s_rd) rd_seq = {rd_seq[5:0], s_addr};
    end
    chk("clean_nrd",  32'(n_rd), 32'd4);
    chk("clean_seq",  32'(rd_seq), 32'h1B);
    chk("clean_nwr",  32'(n_wr), 32'd0);
    chk("clean_nopd", 32'(n_pd), 32'd0);
    step();
    chk("clean_pd",   32'(s_pd), 32'd1);
    chk("clean_wrap", 32'(s_rd && (s_addr == 2'd0)), 32'd1);
    step();
    chk("clean_pd1",  32'(s_pd), 32'd0);

    // Single fault: replica 2 at address 1
    fill(32'h0);
    mem[1][1] = 32'hDEAD_BEEF;
    do_reset();
    scrub_en_i = 1'b1;
    wait_rd(2'd1, ok);
    chk("sf_found", 32'(ok), 32'd1);
    step();
    step();
    chk("sf_wr",    32'(s_wr), 32'b010);
    chk("sf_addr",  32'(s_addr), 32'd1);
    chk("sf_wdata", s_wdata, 32'h0);
    chk("sf_fid",   32'(fault_id_o), 32'd2);
    chk("sf_err",   32'(err_cnt_o), ERRCNT ? 32'd1 : 32'd0);
    chk("sf_mem",   mem[1][1], 32'h0);

    // Triple mismatch at address 2: fatal, sticky, no write
    fill(32'h5);
    mem[0][2] = 32'h1; mem[1][2] = 32'h2; mem[2][2] = 32'h3;
    do_reset();
    scrub_en_i = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      step();
      if (n_pd == 2) ok = 1'b1;
    end
    chk("tm_done",  32'(ok), 32'd1);
    chk("tm_fatal", 32'(fatal_o), 32'd1);
    chk("tm_fid",   32'(fault_id_o), 32'd3);
    chk("tm_nwr",   32'(n_wr), 32'd0);
    chk("tm_mem",   mem[1][2], 32'h2);
    scrub_en_i = 1'b0;
    repeat (6) step();
    chk("tm_sticky", 32'(fatal_o), 32'd1);

    // Core write to the word in REPAIR aborts the repair and re-reads
    fill(32'h0);
    mem[0][3] = 32'hAA;
    do_reset();
    scrub_en_i = 1'b1;
    wait_rd(2'd3, ok);
    chk("col_found", 32'(ok), 32'd1);
    step();
    core_wr_i = 1'b1; core_waddr_i = 2'd3; core_wdata = 32'h77;
    step();
    chk("col_nowr", 32'(s_wr), 32'd0);
    core_wr_i = 1'b0;
    step();
    chk("col_reread", 32'(s_rd && (s_addr == 2'd3)), 32'd1);
    n_wr = 0;
    repeat (10) step();
    chk("col_nwr", 32'(n_wr), 32'd0);
    chk("col_mem", mem[0][3], 32'h77);
    chk("col_err", 32'(err_cnt_o), 32'd0);

    // Stall 5 cycles in REPAIR, then exactly one write
    fill(32'h0);
    mem[2][0] = 32'h1234;
    do_reset();
    scrub_en_i = 1'b1;
    wait_rd(2'd0, ok);
    chk("st_found", 32'(ok), 32'd1);
    step();
    core_busy_i = 1'b1;
    n_wr = 0; n_rd = 0;
    repeat (5) step();
    core_busy_i = 1'b0;
    chk("st_held", 32'(n_wr + n_rd), 32'd0);
    step();
    chk("st_wr",    32'(s_wr), 32'b100);
    chk("st_wdata", s_wdata, 32'h0);
    repeat (4) step();
    chk("st_once",  32'(n_wr), 32'd1);
    chk("st_fid",   32'(fault_id_o), 32'd3);
    chk("st_fatal", 32'(fatal_o), 32'd0);
    chk("st_mem",   mem[2][0], 32'h0);

    // Counter saturation: one repair on a full counter
    fill(32'h0);
    mem[1][0] = 32'h1;
    do_reset();
`ifdef CV32E40P_SCRUB_ERRCNT_EN
    force dut.r_err_cnt = 16'hFFFF;
    #1;
    release dut.r_err_cnt;
`endif
    scrub_en_i = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      step();
      if (s_wr != 3'b000) ok = 1'b1;
    end
    chk("sat_wr", 32'(ok), 32'd1);
    step();
    chk("sat_err", 32'(err_cnt_o), ERRCNT ? 32'hFFFF : 32'd0);

    // Reset in REPAIR suppresses the write immediately
    fill(32'h55);
    mem[0][2] = 32'hF0;
    do_reset();
    scrub_en_i = 1'b1;
    wait_rd(2'd2, ok);
    chk("rr_found", 32'(ok), 32'd1);
    step();
    chk("rr_pre_wr", 32'(wr_en_o), 32'b001);
    rst_n = 1'b0;
    #1;
    chk("rr_wr",    32'(wr_en_o), 32'd0);
    chk("rr_rd",    32'(rd_en_o), 32'd0);
    chk("rr_addr",  32'(addr_o), 32'd0);
    chk("rr_wdata", wdata_o, 32'h0);
    chk("rr_fid",   32'(fault_id_o), 32'd0);
    chk("rr_fatal", 32'(fatal_o), 32'd0);
    chk("rr_pd",    32'(pass_done_o), 32'd0);

    // Enable dropped mid-word: word completes, address kept, resume there
    fill(32'h7);
    do_reset();
    scrub_en_i = 1'b1;
    wait_rd(2'd2, ok);
    chk("en_found", 32'(ok), 32'd1);
    scrub_en_i = 1'b0;
    n_rd = 0;
    repeat (4) step();
    chk("en_idle", 32'(n_rd), 32'd0);
    chk("en_addr", 32'(addr_o), 32'd3);
    scrub_en_i = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 16 && !ok; i++) begin
      step();
      if (s_rd) ok = 1'b1;
    end
    chk("en_resume", 32'(ok && (s_addr == 2'd3)), 32'd1);

    // Randomized words and port stalls, two full passes each
    for (int t = 0; t < 5; t++) begin
      exp_nwr = 0; exp_fid = 0; exp_fatal = 1'b0;
      for (int a = 0; a < int'(DEPTH); a++) begin
        cls[a]  = int'($urandom_range(0, 4));
        base[a] = $urandom;
        for (int k = 0; k < 3; k++) mem[k][a] = base[a];
        if (cls[a] >= 1 && cls[a] <= 3) begin
          mem[cls[a]-1][a] = base[a] ^ ($urandom | 32'h1);
          exp_nwr++;
        end else if (cls[a] == 4) begin
          mem[1][a] = base[a] ^ 32'h1;
          mem[2][a] = base[a] ^ 32'h2;
          exp_fatal = 1'b1;
        end
      end
      // Last fault class seen over two passes; repaired words are clean in pass 2
      for (int p = 0; p < 2; p++)
        for (int a = 0; a < int'(DEPTH); a++) begin
          if (cls[a] == 4) exp_fid = 3;
          else if (cls[a] != 0 && p == 0) exp_fid = cls[a];
        end
      do_reset();
      scrub_en_i = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 400 && !ok; i++) begin
        core_busy_i = ($urandom_range(0, 3) == 0);
        step();
        if (n_pd == 2) ok = 1'b1;
      end
      core_busy_i = 1'b0;
      bad_words = 0;
      for (int a = 0; a < int'(DEPTH); a++) begin
        if (cls[a] == 4) begin
          if (mem[0][a] != base[a] || mem[1][a] != (base[a] ^ 32'h1) ||
              mem[2][a] != (base[a] ^ 32'h2)) bad_words++;
        end else begin
          for (int k = 0; k < 3; k++) if (mem[k][a] != base[a]) bad_words++;
        end
      end
      chk("rnd_done",  32'(ok), 32'd1);
      chk("rnd_nwr",   32'(n_wr), 32'(exp_nwr));
      chk("rnd_fatal", 32'(fatal_o), 32'(exp_fatal));
      chk("rnd_fid",   32'(fault_id_o), 32'(exp_fid));
      chk("rnd_err",   32'(err_cnt_o), ERRCNT ? 32'(exp_nwr) : 32'd0);
      chk("rnd_mem",   32'(bad_words), 32'd0);
    end

    // No multi-hot write and no strobe while the core owned the port
    chk("protocol", 32'(n_bad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cv32e40p_scrub_ctrl.md
CV32E40P_SCRUB_CTRL -- requirements
Module: cv32e40p_scrub_ctrl

Interface
REQ-001 SHALL have parameter NBIT, default 32: width of one replicated data word.
REQ-002 SHALL have parameter DEPTH, default 32: number of words per replica; ADDR_W = $clog2(DEPTH).
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port scrub_en_i, input, 1: enables background scrubbing.
REQ-006 SHALL have port core_busy_i, input, 1: the core owns the replica port this cycle, so the block issues no read or write.
REQ-007 SHALL have port core_wr_i, input, 1: the core writes all three replicas this cycle.
REQ-008 SHALL have port core_waddr_i, input, ADDR_W: the core write address.
REQ-009 SHALL have port addr_o, output, ADDR_W: the scrub address.
REQ-010 SHALL have port rd_en_o, output, 1: scrub read strobe.
REQ-011 SHALL have ports rdata1_i, rdata2_i, rdata3_i, input, NBIT each: replica read data, valid the cycle after rd_en_o.
REQ-012 SHALL have port wr_en_o, output, 3: per-replica repair write enable; bit k selects replica k+1; at most one bit high.
REQ-013 SHALL have port wdata_o, output, NBIT: the voted repair word.
REQ-014 SHALL have port fault_id_o, output, 2: last fault class; 0 none, 1-3 faulty replica, 3 also used by the fatal class (see REQ-021).
REQ-015 SHALL have port fatal_o, output, 1: sticky flag, set when all three replicas differ.
REQ-016 SHALL have port err_cnt_o, output, 16: saturating count of repaired words.
REQ-017 SHALL have port pass_done_o, output, 1: one-cycle pulse on address wrap.

Function
REQ-018 SHALL implement the FSM states IDLE, READ, CHECK, REPAIR.
- IDLE->READ when scrub_en_i=1.
- READ asserts rd_en_o only when core_busy_i=0, then goes to CHECK; otherwise it holds in READ.
REQ-019 SHALL, in CHECK, register the three data words and classify them:
- all equal: advance the address, next state READ or IDLE;
- exactly one differs: latch the majority word and the faulty index, go to REPAIR.
REQ-020 SHALL, in REPAIR with core_busy_i=0, assert the single wr_en_o bit for the faulty replica with wdata_o = majority word, for one cycle, then advance; with core_busy_i=1 it holds in REPAIR.
REQ-021 SHALL, when all three words differ, set fatal_o, set fault_id_o=3, perform no write, and advance.
REQ-022 SHALL, if core_wr_i=1 with core_waddr_i==addr_o while in CHECK or REPAIR, abort any repair and return to READ at the same address.
REQ-023 SHALL give a clean word a latency of 2 cycles (READ, CHECK) and a repaired word 3 cycles, when there are no stalls.
REQ-024 SHALL wrap the address from DEPTH-1 to 0 and pulse pass_done_o in the cycle the wrapping advance occurs.
REQ-025 SHALL, when scrub_en_i falls mid-word, complete the current word including any repair, then enter IDLE; addr_o is retained and scrubbing resumes there.
REQ-026 SHALL make err_cnt_o increment once per completed repair write and saturate at 0xFFFF.
REQ-027 SHALL give the abort of REQ-022 priority over a simultaneous repair write.

Reset
REQ-028 SHALL, on rst_n=0, immediately set state IDLE, addr_o=0, rd_en_o=0, wr_en_o=0, wdata_o=0, fault_id_o=0, fatal_o=0, err_cnt_o=0, pass_done_o=0.
REQ-029 SHALL, on reset mid-repair, suppress the write in the same cycle.
REQ-030 SHALL clear fatal_o only by reset.

Configuration
REQ-031 SHALL, with macro CV32E40P_SCRUB_ERRCNT_EN defined, include the 16-bit saturating error counter.
REQ-032 SHALL, without CV32E40P_SCRUB_ERRCNT_EN, tie err_cnt_o to 0 and leave all other behaviour unchanged.

Structure
REQ-033 SHALL place the FSM state enum and the fault_id encoding constants in the shared package cv32e40p_pkg.
REQ-034 SHALL use one combinational sub-module, cv32e40p_vote_classify, that produces the majority word, a 3-bit mismatch mask and an all-differ flag.

Verification
REQ-035 SHALL cover the clean pass: DEPTH=4, all replicas equal, scrub_en_i=1 -> 8 cycles per pass, pass_done_o pulses once, wr_en_o never asserted.
REQ-036 SHALL cover a single fault: replica 2 at address 1 = 0xDEADBEEF, others 0x0 -> wr_en_o=3'b010, wdata_o=0x0, fault_id_o=2, err_cnt_o=1.
REQ-037 SHALL cover a triple mismatch: 0x1/0x2/0x3 -> fatal_o=1 and sticky, fault_id_o=3, no write.
REQ-038 SHALL cover core collision: core_wr_i=1 with core_waddr_i==addr_o during REPAIR -> no wr_en_o, re-read of the same address.
REQ-039 SHALL cover a stall: core_busy_i=1 for 5 cycles in REPAIR -> the write is delayed 5 cycles, then issued once.
REQ-040 SHALL cover saturation and reset: err_cnt_o preloaded to 0xFFFF plus one repair -> stays 0xFFFF; rst_n low mid-repair -> all outputs 0, no write.
